// File: rtl/spm_pkg.sv
// spm_pkg: shared sizes and loader state encoding for the RISC_SPM memory path
package spm_pkg;
   localparam int spm_word_size = 8;
   localparam int spm_addr_size = 8;
   typedef enum logic [2:0] {IDLE, FLUSH, HDR_ADDR, HDR_CNT, DATA, RELEASE, DONE} loader_state_t;
endpackage

// File: rtl/spm_program_loader.sv
// spm_program_loader: streams address/count/data segments into SPM memory, holding the CPU in reset until loaded
module spm_program_loader
   import spm_pkg::*;
#(
   parameter int word_size = spm_word_size,
   parameter int addr_size = spm_addr_size,
   parameter int mem_depth = 2**addr_size,
   parameter bit flush_en  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [word_size-1:0] s_data,
   output logic                 mem_we,
   output logic [addr_size-1:0] mem_addr,
   output logic [word_size-1:0] mem_wdata,
   output logic                 cpu_rst,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam logic [addr_size-1:0] last_addr = addr_size'(mem_depth - 1);
   loader_state_t state;
   logic [addr_size-1:0] ptr;
   logic [word_size-1:0] rem;
   assign s_ready = state inside {HDR_ADDR, HDR_CNT, DATA};
   assign busy    = !(state inside {IDLE, DONE});
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         rem       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rst   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE, DONE: if (start) begin
               state   <= flush_en ? FLUSH : HDR_ADDR;
               ptr     <= '0;
               done    <= 1'b0;
               err     <= 1'b0;
               cpu_rst <= 1'b0;
            end
            FLUSH: begin
               mem_we    <= 1'b1;
               mem_addr  <= ptr;
               mem_wdata <= '0;
               ptr       <= ptr + 1'b1;
               if (ptr == last_addr) state <= HDR_ADDR;
            end
            HDR_ADDR: if (s_valid) begin
               ptr   <= addr_size'(s_data);
               state <= HDR_CNT;
            end
            HDR_CNT: if (s_valid) begin
               rem   <= s_data;
               state <= (s_data == '0) ? RELEASE : DATA;
            end
            DATA: if (s_valid) begin
               mem_we    <= 1'b1;
               mem_addr  <= ptr;
               mem_wdata <= s_data;
               ptr       <= ptr + 1'b1;
               rem       <= rem - 1'b1;
               // wrapping is only an error if more bytes still need a home
               if (ptr == last_addr && rem != word_size'(1)) err <= 1'b1;
               if (rem == word_size'(1)) state <= HDR_ADDR;
            end
            RELEASE: begin
               state   <= DONE;
               cpu_rst <= 1'b1;
               done    <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spm_program_loader.sv
// tb_spm_program_loader: table, hand-written and random checks against a segment-level memory image model
module tb_spm_program_loader;
   import spm_pkg::*;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, s_valid = 1'b0, sel = 1'b0;
   logic [7:0] s_data = '0;
   logic r0, we0, cr0, b0, d0, e0, r1, we1, cr1, b1, d1, e1;
   logic [7:0] a0, w0, a1, w1;
   logic o_ready, o_we, o_cpu, o_busy, o_done, o_err;
   logic [7:0] o_addr, o_wdata;
   int checks = 0, fails = 0, wr_cnt = 0, exp_wr = 0;
   logic [7:0] mem [256];
   logic [7:0] exp_mem [256];
   logic [7:0] wlog_a [$];
   logic [7:0] wlog_d [$];
   logic [7:0] st [$];
   logic [7:0] main_st [$];
   bit exp_err;

   typedef struct packed {
      logic [0:15][7:0] bytes;
      logic [4:0]       len;
      logic             bp;
      logic             mid_start;
      logic             exp_err;
   } vec_t;
   vec_t tbl [4];

   always #5 clk = ~clk;

   spm_program_loader #(.flush_en(1'b1)) dut0 (
      .clk(clk), .rst(rst), .start(start & ~sel), .s_valid(s_valid & ~sel), .s_ready(r0),
      .s_data(s_data), .mem_we(we0), .mem_addr(a0), .mem_wdata(w0), .cpu_rst(cr0),
      .busy(b0), .done(d0), .err(e0));
   spm_program_loader #(.flush_en(1'b0)) dut1 (
      .clk(clk), .rst(rst), .start(start & sel), .s_valid(s_valid & sel), .s_ready(r1),
      .s_data(s_data), .mem_we(we1), .mem_addr(a1), .mem_wdata(w1), .cpu_rst(cr1),
      .busy(b1), .done(d1), .err(e1));

   assign o_ready = sel ? r1 : r0;
   assign o_we    = sel ? we1 : we0;
   assign o_cpu   = sel ? cr1 : cr0;
   assign o_busy  = sel ? b1 : b0;
   assign o_done  = sel ? d1 : d0;
   assign o_err   = sel ? e1 : e0;
   assign o_addr  = sel ? a1 : a0;
   assign o_wdata = sel ? w1 : w0;

   // memory behind the write port, as the top-level mux would present it
   always @(posedge clk) if (o_we === 1'b1) begin
      mem[o_addr] = o_wdata;
      wr_cnt++;
      wlog_a.push_back(o_addr);
      wlog_d.push_back(o_wdata);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model(input logic [7:0] s [$], input bit fl);
      int i = 0;
      int a, c;
      if (fl) foreach (exp_mem[k]) exp_mem[k] = 8'h00;
      else exp_mem = mem;
      exp_err = 1'b0;
      exp_wr  = fl ? 256 : 0;
      while (i + 1 < s.size()) begin
         a = int'(s[i]);
         c = int'(s[i+1]);
         i += 2;
         if (c == 0) break;
         for (int k = 0; k < c; k++) exp_mem[(a + k) % 256] = s[i+k];
         i += c;
         exp_wr += c;
         if (a + c > 256) exp_err = 1'b1;
      end
   endtask

   task automatic prep();
      foreach (mem[k]) mem[k] = 8'($urandom);
      wr_cnt = 0;
      wlog_a.delete();
      wlog_d.delete();
   endtask

   task automatic push(input logic [7:0] b, input bit bp);
      int t = 0;
      @(negedge clk);
      if (bp) while ($urandom_range(0, 1) == 1) begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = b;
      while (!o_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!o_ready) begin
         checks++;
         fails++;
         $display("FAIL push_timeout: s_ready still %0b after %0d cycles", o_ready, t);
      end
      @(posedge clk);
   endtask

   task automatic run(input logic [7:0] s [$], input bit bp);
      foreach (s[k]) push(s[k], bp);
      @(negedge clk);
      s_valid = 1'b0;
      chk("release_pre cpu_rst/done/busy", {o_cpu, o_done, o_busy}, 3'b001);
      @(negedge clk);
      chk("release cpu_rst/done/busy", {o_cpu, o_done, o_busy}, 3'b110);
   endtask

   task automatic pulse_start(input bit exp_ready);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start cpu_rst/done/err/busy/ready", {o_cpu, o_done, o_err, o_busy, o_ready}, {4'b0001, exp_ready});
   endtask

   task automatic verify(input string name, input bit fl);
      int bad = 0;
      foreach (mem[k]) if (mem[k] !== exp_mem[k]) bad++;
      chk({name, " image_mismatches"}, bad, 0);
      chk({name, " write_count"}, wr_cnt, exp_wr);
      chk({name, " err"}, {31'd0, o_err}, {31'd0, exp_err});
      if (fl) begin
         bad = 0;
         for (int k = 0; k < 256; k++)
            if (k >= wlog_a.size() || wlog_a[k] != 8'(k) || wlog_d[k] != 8'h00) bad++;
         chk({name, " flush_order"}, bad, 0);
      end
   endtask

   initial begin
      main_st = '{8'h00, 8'h03, 8'h51, 8'h82, 8'h16, 8'h80, 8'h03, 8'h06,
                  8'h01, 8'h02, 8'h8B, 8'h02, 8'hF0, 8'h09, 8'h00, 8'h00};
      tbl[0] = '{bytes: '{8'h00, 8'h03, 8'h51, 8'h82, 8'h16, 8'h80, 8'h03, 8'h06,
                          8'h01, 8'h02, 8'h8B, 8'h02, 8'hF0, 8'h09, 8'h00, 8'h00},
                 len: 5'd16, bp: 1'b0, mid_start: 1'b0, exp_err: 1'b0};
      tbl[1] = tbl[0];
      tbl[1].bp = 1'b1;
      tbl[2] = '{bytes: '{8'hFE, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 len: 5'd7, bp: 1'b0, mid_start: 1'b0, exp_err: 1'b1};
      tbl[3] = tbl[0];
      tbl[3].mid_start = 1'b1;
      #1;
      chk("reset dut0 outputs", {r0, we0, cr0, b0, d0, e0, a0, w0}, '0);
      chk("reset dut1 outputs", {r1, we1, cr1, b1, d1, e1, a1, w1}, '0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         st.delete();
         for (int k = 0; k < int'(tbl[i].len); k++) st.push_back(tbl[i].bytes[k]);
         prep();
         model(st, 1'b1);
         pulse_start(1'b0);
         if (tbl[i].mid_start) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("mid_flush start ignored busy/ready", {o_busy, o_ready}, 2'b10);
         end
         run(st, tbl[i].bp);
         verify($sformatf("vec%0d", i), 1'b1);
         chk($sformatf("vec%0d table_err", i), {31'd0, o_err}, {31'd0, tbl[i].exp_err});
         chk($sformatf("vec%0d mem0", i), mem[0], (i == 2) ? 8'hCC : 8'h51);
         chk($sformatf("vec%0d mem139", i), mem[139], (i == 2) ? 8'h00 : 8'hF0);
         repeat (3) @(negedge clk);
         chk($sformatf("vec%0d hold done/err/cpu_rst", i), {o_done, o_err, o_cpu}, {1'b1, tbl[i].exp_err, 1'b1});
      end
      for (int r = 0; r < 4; r++) begin
         st.delete();
         for (int g = $urandom_range(1, 3); g > 0; g--) begin
            int c;
            c = $urandom_range(1, 6);
            st.push_back(8'($urandom));
            st.push_back(8'(c));
            for (int k = 0; k < c; k++) st.push_back(8'($urandom));
         end
         st.push_back(8'($urandom));
         st.push_back(8'h00);
         prep();
         model(st, 1'b1);
         pulse_start(1'b0);
         run(st, 1'($urandom));
         verify($sformatf("rand%0d", r), 1'b1);
      end
      // abort in the middle of a 3-byte segment, while the first write is still on the port
      pulse_start(1'b0);
      push(8'h00, 1'b0);
      push(8'h03, 1'b0);
      push(8'h11, 1'b0);
      @(negedge clk);
      s_data = 8'h22;
      #1 rst = 1'b0;
      #1 chk("async reset outputs", {o_ready, o_we, o_cpu, o_busy, o_done, o_err, o_addr, o_wdata}, '0);
      s_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      prep();
      model(main_st, 1'b1);
      pulse_start(1'b0);
      run(main_st, 1'b0);
      verify("reload_after_reset", 1'b1);
      sel = 1'b1;
      prep();
      model(main_st, 1'b0);
      pulse_start(1'b1);
      run(main_st, 1'b1);
      verify("noflush_first", 1'b0);
      st = '{8'h10, 8'h02, 8'hAB, 8'hCD, 8'h00, 8'h00};
      wr_cnt = 0;
      model(st, 1'b0);
      pulse_start(1'b1);
      run(st, 1'b0);
      verify("noflush_reload", 1'b0);
      chk("noflush_reload mem10", {mem[16], mem[17]}, 16'hABCD);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
